// File: rtl/seg_scan_ctrl.sv
// Scan controller for a bank of common-anode 7-segment digits that share one
// hex decoder. The host writes a display word into a pending buffer, and that
// word is promoted to the active buffer only at a frame boundary (or at once
// while the scan is disabled), so a frame never shows two different words.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_BLANK | all digits off for BLANK_CYC clocks; decoder settles on idx
// ST_SHOW  | digit idx lit for SCAN_DIV clocks
module seg_scan_ctrl #(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [4*DIGITS-1:0] data_in,
    input  logic [DIGITS-1:0]   dp_in,
    input  logic                data_valid,
    output logic                data_ready,
    output logic [3:0]          q_num,
    output logic                seg_dp,
    output logic [DIGITS-1:0]   dig_en_n,
    output logic                frame_done
);

    localparam int MAX_CNT = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CW      = $clog2(MAX_CNT);
    localparam int IW      = $clog2(DIGITS);

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [IW-1:0]       idx, idx_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;

    logic [4*DIGITS-1:0] act_data, pend_data;
    logic [DIGITS-1:0]   act_dp, pend_dp;
    logic                pend, pend_nxt;

    logic [3:0]          q_nxt;
    logic                dp_nxt;
    logic [DIGITS-1:0]   dig_nxt;
    logic                fd_nxt;
    logic                rdy_nxt;

    logic                blank_end, show_end, boundary, capture, copy;

    assign blank_end = (state == ST_BLANK) && (cnt == BLANK_LAST);
    assign show_end  = (state == ST_SHOW) && (cnt == SHOW_LAST);
    assign boundary  = en && show_end && (idx == IDX_LAST);

    // data_ready always mirrors ~pend, so capture and copy never coincide
    assign capture   = data_valid && data_ready;
    assign copy      = pend && (boundary || !en);

    // Scan position registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_BLANK;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next scan position: BLANK -> SHOW -> BLANK of the next digit
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt + 1'b1;
        if (!en) begin
            state_nxt = ST_BLANK;
            idx_nxt   = '0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_BLANK: begin
                    if (blank_end) begin
                        state_nxt = ST_SHOW;
                        cnt_nxt   = '0;
                    end
                end
                ST_SHOW: begin
                    if (show_end) begin
                        state_nxt = ST_BLANK;
                        cnt_nxt   = '0;
                        idx_nxt   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_BLANK;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Output decode from the current position; registered below
    always_comb begin
        q_nxt   = act_data[4*idx +: 4];
        dp_nxt  = act_dp[idx];
        dig_nxt = '1;
        if (en && (state == ST_SHOW)) begin
            dig_nxt[idx] = 1'b0;
        end
        fd_nxt  = boundary;
        rdy_nxt = ~pend_nxt;
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_num      <= '0;
            seg_dp     <= 1'b0;
            dig_en_n   <= '1;
            frame_done <= 1'b0;
            data_ready <= 1'b1;
        end else begin
            q_num      <= q_nxt;
            seg_dp     <= dp_nxt;
            dig_en_n   <= dig_nxt;
            frame_done <= fd_nxt;
            data_ready <= rdy_nxt;
        end
    end

    // Pending flag: a copy clears it, a capture sets it
    always_comb begin
        pend_nxt = pend;
        if (copy) begin
            pend_nxt = 1'b0;
        end else if (capture) begin
            pend_nxt = 1'b1;
        end
    end

    // Double buffer: host writes pending, boundary promotes it to active
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_data  <= '0;
            act_dp    <= '0;
            pend_data <= '0;
            pend_dp   <= '0;
            pend      <= 1'b0;
        end else begin
            pend <= pend_nxt;
            if (capture) begin
                pend_data <= data_in;
                pend_dp   <= dp_in;
            end
            if (copy) begin
                act_data <= pend_data;
                act_dp   <= pend_dp;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl with a frame-position reference model.
module tb_seg_scan_ctrl;

    localparam int D     = 4;
    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int PER   = SD + BC;
    localparam int FRAME = D * PER;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          en = 1'b0;
    logic [4*D-1:0] data_in = '0;
    logic [D-1:0]  dp_in = '0;
    logic          data_valid = 1'b0;
    logic          data_ready;
    logic [3:0]    q_num;
    logic          seg_dp;
    logic [D-1:0]  dig_en_n;
    logic          frame_done;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    typedef struct packed {
        logic [3:0] dig;
        logic [3:0] q;
        logic       dp;
        logic       fd;
        logic       rdy;
    } exp_t;

    exp_t sb[$];
    bit   started = 1'b0;

    // reference model state: position within the frame plus the two buffers
    int          m_t = 0;
    logic [15:0] m_act = '0;
    logic [3:0]  m_act_dp = '0;
    logic [15:0] m_pend = '0;
    logic [3:0]  m_pend_dp = '0;
    bit          m_pf = 1'b0;

    seg_scan_ctrl #(.DIGITS(D), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .q_num      (q_num),
        .seg_dp     (seg_dp),
        .dig_en_n   (dig_en_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cycle, act, exp);
        end
    endtask

    // predictor: at each edge compute what the outputs must show afterwards
    always @(posedge clk) begin
        exp_t e;
        int   pos, dig, ph;
        bit   cap, cpy;
        cycle++;
        if (!rst_n) begin
            m_t = 0; m_act = '0; m_act_dp = '0; m_pend = '0; m_pend_dp = '0; m_pf = 1'b0;
            e = '{dig: 4'hF, q: 4'h0, dp: 1'b0, fd: 1'b0, rdy: 1'b1};
        end else begin
            pos   = m_t;
            dig   = pos / PER;
            ph    = pos % PER;
            e.dig = (en && ph >= BC) ? ~(4'b0001 << dig) : 4'hF;
            e.q   = m_act[dig*4 +: 4];
            e.dp  = m_act_dp[dig];
            e.fd  = en && (pos == FRAME - 1);
            cpy   = m_pf && (e.fd || !en);
            cap   = data_valid && !m_pf;
            if (cpy) begin
                m_act = m_pend; m_act_dp = m_pend_dp; m_pf = 1'b0;
            end
            if (cap) begin
                m_pend = data_in; m_pend_dp = dp_in; m_pf = 1'b1;
            end
            m_t   = en ? (pos + 1) % FRAME : 0;
            e.rdy = !m_pf;
        end
        sb.push_back(e);
        started = 1'b1;
    end

    // monitor: compare the DUT outputs against the queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("dig_en_n", dig_en_n, e.dig);
            check("q_num", q_num, e.q);
            check("seg_dp", seg_dp, e.dp);
            check("frame_done", frame_done, e.fd);
            check("data_ready", data_ready, e.rdy);
        end else if (started) begin
            check("scoreboard_nonempty", 0, 1);
        end
    end

    task automatic wait_fd();
        bit ok = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (frame_done) begin
                ok = 1'b1;
                break;
            end
        end
        check("frame_done_timeout", ok, 1);
    endtask

    task automatic send_word(input logic [15:0] w, input logic [3:0] dp);
        bit ok = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (data_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("data_ready_timeout", ok, 1);
        #1;
        data_in    = w;
        dp_in      = dp;
        data_valid = 1'b1;
        @(negedge clk);
        #1;
        data_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cycle);
        $fatal(1);
    end

    initial begin
        // reset and idle with scan disabled
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (100) @(negedge clk);

        // basic scan of 4321 loaded while disabled
        send_word(16'h4321, 4'b0101);
        repeat (3) @(negedge clk);
        #1 en = 1'b1;
        repeat (2 * FRAME) @(negedge clk);

        // double buffer: write mid-frame, takes effect after the boundary
        wait_fd();
        repeat (13) @(negedge clk);
        send_word(16'hABCD, 4'b1000);
        wait_fd();
        repeat (FRAME / 2) @(negedge clk);

        // boundary collision: valid exactly on the boundary cycle
        wait_fd();
        repeat (FRAME - 1) @(negedge clk);
        #1;
        data_in    = 16'h00FF;
        dp_in      = 4'b0011;
        data_valid = 1'b1;
        @(negedge clk);
        #1 data_valid = 1'b0;
        repeat (2 * FRAME + 5) @(negedge clk);

        // en drop during SHOW of digit 2, then re-enable
        wait_fd();
        repeat (24) @(negedge clk);
        #1 en = 1'b0;
        repeat (4) @(negedge clk);
        #1 en = 1'b1;
        repeat (FRAME + 10) @(negedge clk);

        // randomized traffic: host writes, enable drops
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            #1;
            data_valid = ($urandom_range(0, 15) == 0);
            data_in    = 16'($urandom);
            dp_in      = 4'($urandom);
            if ($urandom_range(0, 149) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
        end
        #1;
        data_valid = 1'b0;
        en         = 1'b1;
        repeat (FRAME) @(negedge clk);

        // asynchronous reset mid-SHOW with a word still pending
        wait_fd();
        repeat (14) @(negedge clk);
        send_word(16'h9876, 4'b1111);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_dig_en_n", dig_en_n, 4'hF);
        check("async_rst_data_ready", data_ready, 1);
        check("async_rst_q_num", q_num, 0);
        check("async_rst_frame_done", frame_done, 0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (FRAME + 10) @(negedge clk);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
